// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the key schedule and the SubBytes datapath.
// The key layout is row-major in the state matrix, so each column word is spread across four byte lanes.
package aes_pkg;

    localparam int unsigned NR_DEFAULT = 10;
    localparam int unsigned KW_DEFAULT = 128;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, HOLD, GEN, DONE} ke_state_t;

    // MSB position of byte (row r, col c) in the 128-bit state.
    function automatic int unsigned byte_msb(input int unsigned r, input int unsigned c);
        return 127 - 8 * (4 * r + c);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub_word
);

    always_comb begin
        sub_word = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sub_word[8*i +: 8] = sbox(word[8*i +: 8]);
        end
    end

endmodule

// File: rtl/key_expansion.sv
// AES-128 round-key generator: loads a cipher key and produces round keys 1..NR on request,
// building each key one column word per clock in a private work register.
module key_expansion
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_DEFAULT,
    parameter int unsigned KW = KW_DEFAULT
)
(
    input  logic          Clk,
    input  logic          Rst,
    input  logic          En_KE,
    input  logic          Nxt_KE,
    input  logic [KW-1:0] In_KE,
    output logic [KW-1:0] Out_KE,
    output logic [3:0]    Rnd_KE,
    output logic          Vld_KE,
    output logic          Ry_KE
);

    ke_state_t     state;
    logic [KW-1:0] work;
    logic [7:0]    rcon;
    logic [1:0]    cnt;

    logic [31:0]   cur_word;
    logic [31:0]   prev_word;
    logic [31:0]   sub_word;
    logic [31:0]   new_word;
    logic [KW-1:0] next_work;
    logic [3:0]    rnd_next;

    function automatic logic [31:0] get_word(input logic [127:0] st, input logic [1:0] c);
        logic [31:0] w;
        w = '0;
        for (int unsigned row = 0; row < 4; row++) begin
            w[31 - 8*row -: 8] = st[byte_msb(row, 32'(c)) -: 8];
        end
        return w;
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] st, input logic [1:0] c,
                                              input logic [31:0] w);
        logic [127:0] r;
        r = st;
        for (int unsigned row = 0; row < 4; row++) begin
            r[byte_msb(row, 32'(c)) -: 8] = w[31 - 8*row -: 8];
        end
        return r;
    endfunction

    // cnt-1 wraps to 3 at c=0, so prev_word is old w3 there and the freshly written w[c-1] otherwise.
    aes_sbox_word u_sbox_word (
        .word     ({prev_word[23:0], prev_word[31:24]}),
        .sub_word (sub_word)
    );

    always_comb begin
        cur_word  = get_word(work, cnt);
        prev_word = get_word(work, cnt - 2'd1);
        new_word  = (cnt == 2'd0) ? (cur_word ^ sub_word ^ {rcon, 24'h0}) : (cur_word ^ prev_word);
        next_work = put_word(work, cnt, new_word);
        rnd_next  = Rnd_KE + 4'd1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            work   <= '0;
            rcon   <= RCON_INIT;
            cnt    <= '0;
            Out_KE <= '0;
            Rnd_KE <= '0;
            Vld_KE <= 1'b0;
            Ry_KE  <= 1'b0;
        end else if (En_KE) begin
            state  <= HOLD;
            work   <= In_KE;
            rcon   <= RCON_INIT;
            cnt    <= '0;
            Out_KE <= In_KE;
            Rnd_KE <= '0;
            Vld_KE <= 1'b1;
            Ry_KE  <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (Nxt_KE) begin
                        state  <= GEN;
                        Vld_KE <= 1'b0;
                        cnt    <= '0;
                    end
                end
                GEN: begin
                    work <= next_work;
                    cnt  <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        Out_KE <= next_work;
                        Rnd_KE <= rnd_next;
                        Vld_KE <= 1'b1;
                        rcon   <= xtime(rcon);
                        if (rnd_next == 4'(NR)) begin
                            state <= DONE;
                            Ry_KE <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                IDLE, DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
